core_dispatch_scheduler: RTL and testbench
==========================================

# core_dispatch_scheduler

Tracks which compute cores are free and offers one idle core at a time to the stream data parser. The parser consumes the offer through its `core_valid`/`core_id` inputs and echoes the chosen core back on `target_core_valid`/`target_core`. Cores return to the pool on a per-core done pulse. Idle cores are selected round-robin, and an optional watchdog reclaims cores that hang.

## Interface
- `CORES`, default 4: number of cores; ≥2; index width `IW = $clog2(CORES)`.
- `TIMEOUT_CYCLES`, default 1000000: busy cycles before watchdog reclaim; only used under `CORE_TIMEOUT_EN`; 32-bit.
- `clk`  in  1  sole clock.
- `reset`  in  1  asynchronous, active-high reset.
- `core_enable`  in  CORES  per-core allow mask; 0 = never offered.
- `core_done`  in  CORES  one-cycle pulse per core: job finished.
- `dispatch_valid`  in  1  parser committed a job (parser `target_core_valid`).
- `dispatch_core`  in  IW  core that received the job (parser `target_core`).
- `clear_errors`  in  1  clears sticky `protocol_error` and `timeout_mask`.
- `core_valid`  out  1  an idle, enabled core is offered.
- `core_id`  out  IW  offered core index.
- `busy_mask`  out  CORES  bit i = core i holds a job.
- `dispatch_count`  out  32  total accepted dispatches; wraps modulo 2^32.
- `protocol_error`  out  1  sticky: illegal dispatch or done.
- `timeout_mask`  out  CORES  sticky per-core watchdog hit; constant 0 without macro.

## Operation
- Reset values (async):
  - `busy_mask` = 0, `core_valid` = 0, `core_id` = 0, `dispatch_count` = 0, `protocol_error` = 0, `timeout_mask` = 0.
  - Round-robin pointer `last_grant` = CORES-1, so the first search starts at core 0.
- Per-cycle busy update, applied in this order:
  1. `core_done[i]`=1 clears busy[i].
  2. Watchdog reclaim clears busy[i].
  3. `dispatch_valid` sets busy[dispatch_core].
- Same-cycle done and redispatch of the same core is legal; the core ends busy.
- Dispatch rules:
  - A dispatch is legal if, after step 1–2 clearing, the target core is not busy, `core_enable`=1, and `dispatch_core` < CORES.
  - Legal dispatch: set busy, increment `dispatch_count`, set `last_grant` = `dispatch_core`.
  - Illegal dispatch: set `protocol_error`; busy and count unchanged.
- `core_done` on a non-busy core sets `protocol_error` and is otherwise ignored.
- Offer logic (registered). Candidate set = cores with next-state busy = 0 and `core_enable` = 1.
  - Hold: if `core_valid`=1, no dispatch this cycle, and the offered core is still a candidate, keep `core_id` unchanged.
  - Otherwise: the next offer is the first candidate scanning `last_grant_next`+1, +2, … modulo CORES. `core_valid` = 1 if any candidate exists, else 0 (`core_id` holds its last value).
- `clear_errors` has priority over new error sets in the same cycle.

## Timing
- Dispatch at edge T: the next offer, computed from post-dispatch busy state, is visible after edge T. The parser returns to its idle state two cycles after sampling the offer, so it never sees a stale offer.
- `core_done` at edge T: the core is eligible in `core_valid`/`core_id` after edge T (1-cycle latency).
- `busy_mask` and `dispatch_count` are registered and update at the same edge as the offer.
- Deasserting `core_enable` for the offered core drops or moves the offer at the next edge.
- Reset mid-job: all cores are forgotten as busy. Jobs in flight are lost; later done pulses flag `protocol_error`.
- Counter wrap: `dispatch_count` goes 0xFFFFFFFF→0 with no flag.

## Configuration
- `CORE_TIMEOUT_EN` defined:
  - Per-core 32-bit busy counter; cleared on dispatch, incremented while busy.
  - When the counter reaches `TIMEOUT_CYCLES-1` with no done pulse, the core is freed next edge and `timeout_mask[i]` is set (sticky).
  - A done pulse arriving in the reclaim cycle takes normal done priority; no timeout is flagged.
- `CORE_TIMEOUT_EN` undefined: no counters; `timeout_mask` is tied to 0; busy clears only via `core_done`.

## Test plan
- Reset, `core_enable`=4'b1111, no traffic → after 1 cycle `core_valid`=1, `core_id`=0, `busy_mask`=0.
- Dispatch cores 0,1,2,3 back-to-back as offered → offers 1,2,3 follow; after the 4th dispatch `core_valid`=0, `busy_mask`=4'b1111, `dispatch_count`=4.
- All busy, pulse `core_done[2]` → next cycle `core_valid`=1, `core_id`=2; then dispatch 2 → `core_valid`=0.
- `core_enable`=4'b1010, fresh reset → offers alternate 1, 3, 1, … as each dispatch is followed by its done; core 0 is never offered.
- Dispatch core 1 while busy, and `core_done[3]` while idle → `protocol_error`=1, `busy_mask` unchanged; `clear_errors` → 0 next cycle.
- With `CORE_TIMEOUT_EN`, `TIMEOUT_CYCLES`=16: dispatch core 0, no done → freed after 16 cycles, `timeout_mask`=4'b0001, core 0 offered again.

Source files
------------

// File: rtl/core_dispatch_scheduler.sv
// Round-robin idle-core offer logic with busy tracking and dispatch accounting.
// Optional per-core watchdog reclaim is enabled by defining CORE_TIMEOUT_EN.
module core_dispatch_scheduler #(
  parameter int unsigned CORES          = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  localparam int unsigned IW            = $clog2(CORES)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [CORES-1:0] core_enable,
  input  logic [CORES-1:0] core_done,
  input  logic             dispatch_valid,
  input  logic [IW-1:0]    dispatch_core,
  input  logic             clear_errors,
  output logic             core_valid,
  output logic [IW-1:0]    core_id,
  output logic [CORES-1:0] busy_mask,
  output logic [31:0]      dispatch_count,
  output logic             protocol_error,
  output logic [CORES-1:0] timeout_mask
);

  if (CORES < 2 || TIMEOUT_CYCLES == 0) begin : g_invalid_params
  end

  logic [IW-1:0]    last_grant;
  logic [CORES-1:0] reclaim;
  logic [CORES-1:0] busy_cleared;
  logic [CORES-1:0] dispatch_onehot;
  logic [CORES-1:0] busy_next;
  logic [CORES-1:0] cand;
  logic [IW-1:0]    lg_next;
  logic [IW-1:0]    pick;
  logic [31:0]      scan_idx;
  logic             in_range;
  logic             legal;
  logic             done_err;
  logic             hold;
  logic             found;
  logic             next_valid;
  logic             err_next;

  if (CORES == (1 << IW)) begin : g_full_range
    assign in_range = 1'b1;
  end else begin : g_part_range
    assign in_range = (32'(dispatch_core) < CORES);
  end

  always_comb begin
    busy_cleared    = busy_mask & ~core_done & ~reclaim;
    done_err        = |(core_done & ~busy_mask);
    legal           = dispatch_valid & in_range & ~busy_cleared[dispatch_core]
                      & core_enable[dispatch_core];
    dispatch_onehot = legal ? (CORES'(1) << dispatch_core) : '0;
    busy_next       = busy_cleared | dispatch_onehot;
    lg_next         = legal ? dispatch_core : last_grant;
    cand            = ~busy_next & core_enable;
    hold            = core_valid & ~dispatch_valid & cand[core_id];
    err_next        = clear_errors ? 1'b0
                      : (protocol_error | done_err | (dispatch_valid & ~legal));
    // Scan starts one past the most recent grant so every enabled core gets a turn.
    found    = 1'b0;
    pick     = core_id;
    scan_idx = '0;
    for (int unsigned k = 1; k <= CORES; k++) begin
      scan_idx = (32'(lg_next) + k) % CORES;
      if (!found && cand[scan_idx[IW-1:0]]) begin
        found = 1'b1;
        pick  = scan_idx[IW-1:0];
      end
    end
    next_valid = hold | found;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_mask      <= '0;
      last_grant     <= IW'(CORES - 1);
      core_valid     <= 1'b0;
      core_id        <= '0;
      dispatch_count <= '0;
      protocol_error <= 1'b0;
    end else begin
      busy_mask      <= busy_next;
      last_grant     <= lg_next;
      core_valid     <= next_valid;
      core_id        <= hold ? core_id : pick;
      dispatch_count <= dispatch_count + 32'(legal);
      protocol_error <= err_next;
    end
  end

`ifdef CORE_TIMEOUT_EN
  logic [31:0] busy_cnt [CORES];

  always_comb begin
    reclaim = '0;
    for (int unsigned i = 0; i < CORES; i++) begin
      reclaim[i] = busy_mask[i] & ~core_done[i] & (busy_cnt[i] == TIMEOUT_CYCLES - 1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < CORES; i++) busy_cnt[i] <= '0;
      timeout_mask <= '0;
    end else begin
      for (int unsigned i = 0; i < CORES; i++) begin
        if (dispatch_onehot[i])   busy_cnt[i] <= '0;
        else if (busy_cleared[i]) busy_cnt[i] <= busy_cnt[i] + 32'd1;
        else                      busy_cnt[i] <= '0;
      end
      timeout_mask <= clear_errors ? '0 : (timeout_mask | reclaim);
    end
  end
`else
  assign reclaim      = '0;
  assign timeout_mask = '0;
`endif

endmodule

// File: tb/tb_core_dispatch_scheduler.sv
// Self-checking bench: behavioural scheduler model, directed test-plan cases, randomized traffic.
module tb_core_dispatch_scheduler;
  localparam int unsigned CORES = 4;
  localparam int unsigned TO    = 16;
  localparam int unsigned IW    = 2;

  logic             clk;
  logic             reset;
  logic [CORES-1:0] core_enable;
  logic [CORES-1:0] core_done;
  logic             dispatch_valid;
  logic [IW-1:0]    dispatch_core;
  logic             clear_errors;
  logic             core_valid;
  logic [IW-1:0]    core_id;
  logic [CORES-1:0] busy_mask;
  logic [31:0]      dispatch_count;
  logic             protocol_error;
  logic [CORES-1:0] timeout_mask;

  core_dispatch_scheduler #(.CORES(CORES), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .core_enable(core_enable), .core_done(core_done),
    .dispatch_valid(dispatch_valid), .dispatch_core(dispatch_core),
    .clear_errors(clear_errors), .core_valid(core_valid), .core_id(core_id),
    .busy_mask(busy_mask), .dispatch_count(dispatch_count),
    .protocol_error(protocol_error), .timeout_mask(timeout_mask)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model state
  bit [CORES-1:0] m_busy;
  int unsigned    m_lg;
  bit             m_cv;
  int unsigned    m_cid;
  logic [31:0]    m_cnt;
  bit             m_err;
  bit [CORES-1:0] m_to;
  int unsigned    m_tc [CORES];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy = '0; m_lg = CORES - 1; m_cv = 0; m_cid = 0;
    m_cnt = '0; m_err = 0; m_to = '0;
    for (int i = 0; i < CORES; i++) m_tc[i] = 0;
  endtask

  task automatic model_step();
    bit [CORES-1:0] b;
    bit [CORES-1:0] ts;
    bit es;
    bit legal;
    int unsigned dc;
    int unsigned idx;
    b = m_busy; es = 0; ts = '0; legal = 0;
    for (int i = 0; i < CORES; i++)
      if (core_done[i]) begin
        if (m_busy[i]) b[i] = 0;
        else es = 1;
      end
`ifdef CORE_TIMEOUT_EN
    for (int i = 0; i < CORES; i++)
      if (m_busy[i] && !core_done[i] && m_tc[i] == TO - 1) begin
        b[i] = 0; ts[i] = 1;
      end
`endif
    dc = dispatch_core;
    if (dispatch_valid) begin
      if (dc < CORES && !b[dc] && core_enable[dc]) begin
        legal = 1; b[dc] = 1; m_cnt = m_cnt + 1; m_lg = dc;
      end else es = 1;
    end
    for (int i = 0; i < CORES; i++) begin
      if (legal && i == dc) m_tc[i] = 0;
      else if (b[i])        m_tc[i] = m_tc[i] + 1;
      else                  m_tc[i] = 0;
    end
    if (!(m_cv && !dispatch_valid && !b[m_cid] && core_enable[m_cid])) begin
      m_cv = 0;
      for (int unsigned k = 1; k <= CORES; k++) begin
        idx = (m_lg + k) % CORES;
        if (!m_cv && !b[idx] && core_enable[idx]) begin
          m_cv = 1; m_cid = idx;
        end
      end
    end
    m_busy = b;
    m_err  = clear_errors ? 1'b0 : (m_err | es);
    m_to   = clear_errors ? '0 : (m_to | ts);
  endtask

  task automatic compare();
    chk("busy_mask", 32'(busy_mask), 32'(m_busy));
    chk("core_valid", 32'(core_valid), 32'(m_cv));
    if (m_cv) chk("core_id", 32'(core_id), m_cid);
    chk("dispatch_count", dispatch_count, m_cnt);
    chk("protocol_error", 32'(protocol_error), 32'(m_err));
    chk("timeout_mask", 32'(timeout_mask), 32'(m_to));
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare();
  endtask

  task automatic idle_inputs();
    core_done = '0; dispatch_valid = 0; dispatch_core = '0; clear_errors = 0;
  endtask

  // Called at a negedge; checks the asynchronous reset values before any clock edge.
  task automatic do_reset();
    idle_inputs();
    reset = 1;
    model_reset();
    #1;
    chk("rst_core_valid", 32'(core_valid), 0);
    chk("rst_core_id", 32'(core_id), 0);
    chk("rst_busy", 32'(busy_mask), 0);
    chk("rst_count", dispatch_count, 0);
    chk("rst_err", 32'(protocol_error), 0);
    chk("rst_timeout", 32'(timeout_mask), 0);
    @(posedge clk);
    @(negedge clk);
    reset = 0;
  endtask

  task automatic dispatch(input int unsigned c);
    idle_inputs(); dispatch_valid = 1; dispatch_core = IW'(c);
    cycle();
  endtask

  initial begin
    reset = 0; core_enable = '1; idle_inputs();
    @(negedge clk);

    // All enabled: first offer core 0, then 1,2,3 as each is dispatched
    core_enable = 4'b1111;
    do_reset();
    cycle();
    chk("init_valid", 32'(core_valid), 1);
    chk("init_id", 32'(core_id), 0);
    chk("init_busy", 32'(busy_mask), 0);
    for (int k = 0; k < 4; k++) begin
      dispatch(k);
      if (k < 3) chk("b2b_next_id", 32'(core_id), k + 1);
    end
    chk("full_valid", 32'(core_valid), 0);
    chk("full_busy", 32'(busy_mask), 32'hF);
    chk("full_count", dispatch_count, 4);
    idle_inputs(); core_done = 4'b0100;
    cycle();
    chk("done2_valid", 32'(core_valid), 1);
    chk("done2_id", 32'(core_id), 2);
    dispatch(2);
    chk("redisp2_valid", 32'(core_valid), 0);

    // Enable 1010: offers alternate 1,3 and never 0
    core_enable = 4'b1010;
    do_reset();
    idle_inputs();
    cycle();
    for (int j = 0; j < 6; j++) begin
      chk("alt_offer", 32'(core_id), (j % 2 == 0) ? 1 : 3);
      dispatch(core_id);
      idle_inputs(); core_done = 4'b0001 << ((j % 2 == 0) ? 1 : 3);
      cycle();
    end

    // Protocol errors and clearing
    core_enable = 4'b1111;
    do_reset();
    idle_inputs();
    cycle();
    dispatch(1);
    idle_inputs(); dispatch_valid = 1; dispatch_core = 2'd1; core_done = 4'b1000;
    cycle();
    chk("perr_set", 32'(protocol_error), 1);
    chk("perr_busy", 32'(busy_mask), 32'h2);
    idle_inputs(); clear_errors = 1;
    cycle();
    chk("perr_clear", 32'(protocol_error), 0);

`ifdef CORE_TIMEOUT_EN
    core_enable = 4'b0001;
    do_reset();
    idle_inputs();
    cycle();
    dispatch(0);
    idle_inputs();
    for (int k = 0; k < 15; k++) cycle();
    chk("wd_still_busy", 32'(busy_mask), 1);
    cycle();
    chk("wd_freed", 32'(busy_mask), 0);
    chk("wd_mask", 32'(timeout_mask), 1);
    chk("wd_offer_valid", 32'(core_valid), 1);
    chk("wd_offer_id", 32'(core_id), 0);
`endif

    // Randomized traffic
    core_enable = 4'b1111;
    do_reset();
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 399) == 0) do_reset();
      if ($urandom_range(0, 49) == 0) core_enable = CORES'($urandom_range(1, 15));
      idle_inputs();
      if (m_cv && $urandom_range(0, 99) < 60) begin
        dispatch_valid = 1; dispatch_core = IW'(m_cid);
      end else if ($urandom_range(0, 99) < 5) begin
        dispatch_valid = 1; dispatch_core = IW'($urandom_range(0, 3));
      end
      for (int i = 0; i < CORES; i++)
        core_done[i] = m_busy[i] ? ($urandom_range(0, 99) < 10) : ($urandom_range(0, 99) < 1);
      clear_errors = ($urandom_range(0, 99) < 3);
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
